// File: rtl/sys2_pkg.sv
// Shared definitions for the system2 sweep controller: FSM states, vector sizing
// and a helper that locates the lowest set bit of a truth-table difference.
`timescale 1ns/1ps
package sys2_pkg;

    localparam int VEC_W = 3;
    localparam int N_VEC = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_t;

    // Returns the lowest index with a 1 bit; 0 when the vector is all zero.
    function automatic logic [VEC_W-1:0] lowest_set(input logic [N_VEC-1:0] v);
        logic [VEC_W-1:0] pos;
        pos = '0;
        for (int i = N_VEC - 1; i >= 0; i--) begin
            if (v[i]) pos = VEC_W'(i);
        end
        return pos;
    endfunction

endpackage

// File: rtl/sys2_sweep_ctrl.sv
// Sweeps all eight {va,vb,vc} vectors into system2 and captures outa as an 8-bit truth table.
// Define SWEEP_CHECK_EN to compare the captured table against expect_q at sweep end.
`timescale 1ns/1ps
module sys2_sweep_ctrl
    import sys2_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       va,
    output logic       vb,
    output logic       vc,
    input  logic       outa,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_q,
    output logic       valid
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [7:0] expect_q,
    output logic       mismatch,
    output logic [2:0] fail_idx
`endif
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [VEC_W-1:0] IDX_LAST    = VEC_W'(N_VEC - 1);

    sweep_state_t       state_reg;
    logic [VEC_W-1:0]   idx_reg;
    logic [3:0]         settle_reg;
    logic [VEC_W-1:0]   vec_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               valid_reg;
    logic [N_VEC-1:0]   table_reg;
    logic [N_VEC-1:0]   table_next;

`ifdef SWEEP_CHECK_EN
    logic               mismatch_reg;
    logic [VEC_W-1:0]   fail_idx_reg;
`endif

    // Table as it will look once the current vector's outa is captured.
    always_comb begin
        table_next          = table_reg;
        table_next[idx_reg] = outa;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            settle_reg   <= '0;
            vec_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            table_reg    <= '0;
`ifdef SWEEP_CHECK_EN
            mismatch_reg <= 1'b0;
            fail_idx_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg    <= ST_DRIVE;
                        idx_reg      <= '0;
                        settle_reg   <= '0;
                        vec_reg      <= '0;
                        busy_reg     <= 1'b1;
                        valid_reg    <= 1'b0;
                        table_reg    <= '0;
`ifdef SWEEP_CHECK_EN
                        mismatch_reg <= 1'b0;
                        fail_idx_reg <= '0;
`endif
                    end
                end
                ST_DRIVE: begin
                    if (settle_reg == SETTLE_LAST) begin
                        settle_reg <= '0;
                        state_reg  <= ST_SAMPLE;
                    end else begin
                        settle_reg <= settle_reg + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    table_reg <= table_next;
                    if (idx_reg == IDX_LAST) begin
                        // Terminal vector: the sweep ends here, idx never wraps.
                        state_reg    <= ST_DONE;
                        vec_reg      <= '0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        valid_reg    <= 1'b1;
`ifdef SWEEP_CHECK_EN
                        mismatch_reg <= (table_next != expect_q);
                        fail_idx_reg <= lowest_set(table_next ^ expect_q);
`endif
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        vec_reg   <= idx_reg + 1'b1;
                        state_reg <= ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign {va, vb, vc} = vec_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign valid        = valid_reg;
    assign table_q      = table_reg;
`ifdef SWEEP_CHECK_EN
    assign mismatch     = mismatch_reg;
    assign fail_idx     = fail_idx_reg;
`endif

endmodule

// File: doc/sys2_sweep_ctrl.md
SYS2_SWEEP_CTRL -- requirements
Module: sys2_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2: cycles each input vector is held before outa is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request one full sweep; sampled in IDLE only.
REQ-005 SHALL have ports va, vb, vc, output, 1 each: drive the system2 inputs.
REQ-006 SHALL have port outa, input, 1: system2 output under sweep.
REQ-007 SHALL have port busy, output, 1: high in DRIVE or SAMPLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the sweep completes.
REQ-009 SHALL have port table_q, output, 8: captured truth table; bit i = outa for {va,vb,vc}=i.
REQ-010 SHALL have port valid, output, 1: table_q holds a complete sweep.

Function
REQ-011 SHALL implement FSM IDLE, DRIVE, SAMPLE, DONE with a 3-bit vector index idx and a 4-bit settle counter.
REQ-012 SHALL drive {va,vb,vc} = idx (va MSB) in DRIVE and SAMPLE, and 3'b000 in IDLE and DONE.
REQ-013 SHALL move IDLE->DRIVE on a clock edge with start=1; on that edge idx=0, settle counter=0, valid=0, table_q=0.
REQ-014 SHALL stay in DRIVE for exactly SETTLE_CYC cycles per vector, then enter SAMPLE.
REQ-015 SHALL, on the edge leaving SAMPLE, write table_q[idx]=outa; then go to DONE if idx==7, else increment idx and return to DRIVE.
REQ-016 SHALL hold SAMPLE for exactly one cycle, giving 8*(SETTLE_CYC+1) cycles from first DRIVE cycle to first DONE cycle.
REQ-017 SHALL assert done and set valid in the single DONE cycle, then return to IDLE; valid stays high until the next accepted start or reset.
REQ-018 SHALL ignore start in DRIVE, SAMPLE and DONE; no queuing.
REQ-019 SHALL keep table_q stable outside SAMPLE-exit edges.
REQ-020 SHALL NOT wrap idx past 7; the terminal vector ends the sweep.

Reset
REQ-021 SHALL, on rst=1 at any time, including mid-sweep, force IDLE, idx=0, settle=0, va=vb=vc=0, busy=0, done=0, valid=0, table_q=8'h00 without waiting for clk.
REQ-022 SHALL accept start on the first clock edge after rst deasserts.

Configuration
REQ-023 SHALL, with SWEEP_CHECK_EN defined, add input expect_q[7:0] and outputs mismatch (1) and fail_idx (3).
REQ-024 SHALL, with SWEEP_CHECK_EN defined, set mismatch=(table_q!=expect_q) and fail_idx = lowest differing bit index (0 if none) in the DONE cycle; both clear on accepted start or reset, otherwise hold.
REQ-025 SHALL, without SWEEP_CHECK_EN, omit those ports and logic; all other behaviour is identical.

Structure
REQ-026 SHALL place the FSM state enum, VEC_W=3 and N_VEC=8 in shared package sys2_pkg.
REQ-027 SHALL be a single module with no sub-modules; system2 is instantiated beside it, not inside it.

Verification
REQ-028 Bench model outa=va^vb^vc, SETTLE_CYC=2, pulse start -> done exactly 24 cycles after the first DRIVE cycle, table_q=8'h96, valid=1.
REQ-029 Bench model outa tied 1, SETTLE_CYC=1 -> table_q=8'hFF; va/vb/vc step 000..111, each held 2 cycles.
REQ-030 Hold start high throughout the sweep -> exactly one done pulse per sweep, and the second sweep starts only from IDLE.
REQ-031 Assert rst while idx=4 -> all outputs zero immediately, with no clk edge needed; a new start gives a clean full sweep.
REQ-032 With SWEEP_CHECK_EN and outa=va^vb^vc: expect_q=8'h96 gives mismatch=0; expect_q=8'h94 gives mismatch=1 and fail_idx=1.
